// File: rtl/bike_pkg.sv
// Shared constants, speed-conversion helper and measurement FSM encoding for the bike-computer datapath.
package bike_pkg;

    localparam int SPEED_WIDTH = 12;
    localparam int CLK_HZ      = 1_000_000;
    localparam int CIRC_MM     = 2133;

    // km/h = (circ_mm / 1e6 km) / (period / clk_hz s) * 3600 = K / period
    function automatic longint unsigned speed_k(input longint unsigned circ_mm,
                                                input longint unsigned clk_hz);
        return (circ_mm * clk_hz * 64'd36) / 64'd10000;
    endfunction

    localparam longint unsigned SPEED_K = speed_k(64'(CIRC_MM), 64'(CLK_HZ));

    typedef logic [1:0] meas_state_t;

    localparam meas_state_t ST_IDLE = 2'd0;
    localparam meas_state_t ST_LOAD = 2'd1;
    localparam meas_state_t ST_DIV  = 2'd2;
    localparam meas_state_t ST_DONE = 2'd3;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, WIDTH cycles after load.
// done is high in the cycle retiring the last bit; quotient is final from the next cycle until the next load.
module seq_divider #(
    parameter int WIDTH = 24
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic [CW-1:0]    r_left;
    logic [WIDTH:0]   w_shift;
    logic             w_fits;

    // r_quo shifts the dividend out of its top while quotient bits enter at the bottom
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_fits  = w_shift >= {1'b0, r_dvs};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_dvs  <= '0;
            r_left <= '0;
        end else if (load) begin
            r_rem  <= '0;
            r_quo  <= dividend;
            r_dvs  <= divisor;
            r_left <= CW'(WIDTH);
        end else if (r_left != '0) begin
            r_rem  <= w_fits ? (w_shift[WIDTH-1:0] - r_dvs) : w_shift[WIDTH-1:0];
            r_quo  <= {r_quo[WIDTH-2:0], w_fits};
            r_left <= r_left - 1'b1;
        end
    end

    assign quotient = r_quo;
    assign done     = (r_left == CW'(1));

endmodule

// File: rtl/speed_meter.sv
// Wheel period measurement and km/h conversion; speed_valid follows speed_start by PERIOD_WIDTH+2 cycles.
// speed_start while busy is dropped, never queued; wheel_pulse marks each debounced rising edge.
module speed_meter #(
    parameter int SPEED_WIDTH    = bike_pkg::SPEED_WIDTH,
    parameter int CLK_HZ         = bike_pkg::CLK_HZ,
    parameter int CIRC_MM        = bike_pkg::CIRC_MM,
    parameter int PERIOD_WIDTH   = 24,
    parameter int DEB_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 3_000_000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   wheel,
    input  logic                   speed_start,
    output logic [SPEED_WIDTH-1:0] speed,
    output logic                   speed_valid,
    output logic                   busy,
    output logic                   wheel_pulse
);

    import bike_pkg::*;

    localparam longint unsigned K = speed_k(64'(CIRC_MM), 64'(CLK_HZ));
    localparam logic [PERIOD_WIDTH-1:0] K_V    = PERIOD_WIDTH'(K);
    localparam logic [PERIOD_WIDTH-1:0] TMO_V  = PERIOD_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [PERIOD_WIDTH-1:0] SMAX_V = PERIOD_WIDTH'((64'd1 << SPEED_WIDTH) - 64'd1);
    localparam int DW = $clog2(DEB_CYCLES + 1);

    generate
        if (K >= (64'd1 << PERIOD_WIDTH)) begin : g_k_too_wide
            $error("speed_meter: speed constant K does not fit in PERIOD_WIDTH");
        end
    endgenerate

    logic [1:0]    r_sync;
    logic          r_deb;
    logic [DW-1:0] r_deb_cnt;
    logic          r_pulse;
    logic          w_sync;
    logic          w_flip;

    assign w_sync = r_sync[1];
    assign w_flip = (w_sync != r_deb) && (r_deb_cnt == DW'(DEB_CYCLES - 1));

    // r_deb_cnt counts consecutive cycles the synchronised input disagrees with the debounced level
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync    <= '0;
            r_deb     <= 1'b0;
            r_deb_cnt <= '0;
            r_pulse   <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], wheel};
            r_pulse <= w_flip && w_sync;
            if (w_sync == r_deb) begin
                r_deb_cnt <= '0;
            end else if (w_flip) begin
                r_deb     <= w_sync;
                r_deb_cnt <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + 1'b1;
            end
        end
    end

    logic [PERIOD_WIDTH-1:0] r_cnt;
    logic [PERIOD_WIDTH-1:0] r_last;
    logic [1:0]              r_npulse;
    logic                    w_seen2;

    assign w_seen2 = r_npulse[1];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt    <= '0;
            r_last   <= '0;
            r_npulse <= '0;
        end else if (r_pulse) begin
            r_cnt  <= PERIOD_WIDTH'(1);
            r_last <= r_cnt;
            if (!w_seen2) begin
                r_npulse <= r_npulse + 1'b1;
            end
        end else if (r_cnt < TMO_V) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    meas_state_t             r_state;
    logic [PERIOD_WIDTH-1:0] r_d;
    logic                    r_zero;
    logic [SPEED_WIDTH-1:0]  r_speed;
    logic [PERIOD_WIDTH-1:0] w_snap;
    logic [PERIOD_WIDTH-1:0] w_quo;
    logic                    w_div_done;
    logic [SPEED_WIDTH-1:0]  w_result;

    // Taking the larger of the last period and the open one makes speed decay while slowing
    assign w_snap = (r_cnt > r_last) ? r_cnt : r_last;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_d     <= '0;
            r_zero  <= 1'b1;
            r_speed <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (speed_start) begin
                        r_d     <= w_snap;
                        r_zero  <= !w_seen2 || (w_snap >= TMO_V);
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: r_state <= ST_DIV;
                ST_DIV: begin
                    if (w_div_done) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_speed <= w_result;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    seq_divider #(
        .WIDTH (PERIOD_WIDTH)
    ) u_div (
        .clock    (clock),
        .reset    (reset),
        .load     (r_state == ST_LOAD),
        .dividend (K_V),
        .divisor  (r_d),
        .quotient (w_quo),
        .done     (w_div_done)
    );

    assign w_result = r_zero           ? '0 :
                      (w_quo > SMAX_V) ? '1 :
                                         w_quo[SPEED_WIDTH-1:0];

    assign speed       = (r_state == ST_DONE) ? w_result : r_speed;
    assign speed_valid = (r_state == ST_DONE);
    assign busy        = (r_state != ST_IDLE);
    assign wheel_pulse = r_pulse;

endmodule

// File: tb/tb_speed_meter.sv
// Randomised bench for speed_meter with scaled clock/circumference so whole rides fit in a short run.
`timescale 1ns/1ps
module tb_speed_meter;

    localparam int SW    = 12;
    localparam int PW    = 24;
    localparam int DEB   = 16;
    localparam int TMO   = 8000;
    localparam int CLKHZ = 10_000;
    localparam int CIRC  = 21_330;
    localparam longint KCONST = (64'(CIRC) * 64'(CLKHZ) * 64'd36) / 64'd10000;
    localparam int SMAX  = (1 << SW) - 1;
    localparam int LAT   = PW + 2;
    localparam int PLAT  = DEB + 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          wheel = 1'b0;
    logic          speed_start = 1'b0;
    logic [SW-1:0] speed;
    logic          speed_valid;
    logic          busy;
    logic          wheel_pulse;

    speed_meter #(
        .SPEED_WIDTH    (SW),
        .CLK_HZ         (CLKHZ),
        .CIRC_MM        (CIRC),
        .PERIOD_WIDTH   (PW),
        .DEB_CYCLES     (DEB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .wheel       (wheel),
        .speed_start (speed_start),
        .speed       (speed),
        .speed_valid (speed_valid),
        .busy        (busy),
        .wheel_pulse (wheel_pulse)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    int n_pulse = 0;
    int n_valid = 0;
    int last_pulse_c = -1000;
    int exp_pulses = 0;
    int last_e = 0;
    int prev_e = 0;
    int n_e = 0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (wheel_pulse) begin
            n_pulse++;
            last_pulse_c = cyc;
        end
        if (speed_valid) n_valid++;
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Expected speed for a request seen in cycle s, from the ride history alone
    function automatic int model_speed(input int s);
        int per, el, d;
        if (n_e < 2) return 0;
        per = last_e - prev_e;
        el  = s - last_e - PLAT;
        d   = (per > el) ? per : el;
        if (d >= TMO) return 0;
        if (KCONST / d > SMAX) return SMAX;
        return int'(KCONST / d);
    endfunction

    function automatic bit stable(input int s);
        return (model_speed(s - 1) == model_speed(s)) && (model_speed(s + 1) == model_speed(s));
    endfunction

    task automatic edge_then(input int gap);
        int ec;
        ec = cyc;
        wheel = 1'b1;
        tick(30);
        chk("pulse_lat", ((last_pulse_c - ec) >= PLAT - 1) && ((last_pulse_c - ec) <= PLAT + 1), 1);
        wheel = 1'b0;
        prev_e = last_e;
        last_e = ec;
        n_e++;
        exp_pulses++;
        tick(gap - 30);
    endtask

    task automatic measure(input string tag, input int exp, input int re_at);
        int sc, vc, v0;
        v0 = n_valid;
        sc = cyc;
        vc = -1;
        speed_start = 1'b1;
        for (int i = 0; i < LAT + 10 && vc < 0; i++) begin
            @(posedge clock);
            #1;
            speed_start = (re_at > 0) && (cyc == sc + re_at);
            if (cyc == sc + 1) chk({tag, "_busy"}, busy, 1);
            if (speed_valid) vc = cyc;
        end
        speed_start = 1'b0;
        chk({tag, "_lat"}, vc - sc, LAT);
        chk({tag, "_speed"}, speed, exp);
        tick(1);
        chk({tag, "_idle"}, busy, 0);
        tick(3);
        chk({tag, "_hold"}, speed, exp);
        chk({tag, "_nvalid"}, n_valid - v0, 1);
    endtask

    task automatic steady(input string tag, input int p, input int re_at);
        edge_then(p);
        edge_then(p);
        edge_then(40 + $urandom_range(0, 20));
        measure(tag, model_speed(cyc), re_at);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, tgt, ec, v0, seen;

        tick(3);
        reset = 1'b0;
        chk("rst_speed", speed, 0);
        chk("rst_valid", speed_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pulse", wheel_pulse, 0);

        measure("startup", 0, 0);

        for (int s = 0; s < 4; s++) begin
            p = $urandom_range(200, 2000);
            steady("steady", p, (s % 2 == 1) ? $urandom_range(2, 20) : 0);
            tgt = p + $urandom_range(1, p);
            tick(tgt - (cyc - last_e - PLAT));
            for (int k = 0; k < 20 && !stable(cyc); k++) tick(1);
            measure("decay", model_speed(cyc), 0);
        end
        chk("pulse_count", n_pulse, exp_pulses);

        steady("sat187", 187, 0);
        chk("sat187_val", model_speed(cyc - 36), SMAX);
        steady("edge188", 188, 0);
        steady("sat100", 100, 7);

        steady("pre_glitch", 600, 0);
        for (int g = 0; g < 4; g++) begin
            wheel = 1'b1;
            tick($urandom_range(1, DEB - 4));
            wheel = 1'b0;
            tick(25);
        end
        chk("glitch_pulses", n_pulse, exp_pulses);
        measure("glitch", model_speed(cyc), 0);

        // Next edge 400 cycles after the last one; request lands on its pulse
        tick(last_e + 400 - cyc);
        ec = cyc;
        wheel = 1'b1;
        seen = 0;
        for (int k = 0; k < 40 && seen == 0; k++) begin
            @(negedge clock);
            seen = wheel_pulse;
        end
        chk("coll_pulse", seen, 1);
        measure("collide", model_speed(cyc), 0);
        wheel = 1'b0;
        prev_e = last_e;
        last_e = ec;
        n_e++;
        exp_pulses++;
        measure("after_coll", model_speed(cyc), 0);
        chk("coll_count", n_pulse, exp_pulses);

        v0 = n_valid;
        speed_start = 1'b1;
        tick(1);
        speed_start = 1'b0;
        tick(9);
        reset = 1'b1;
        tick(1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_speed", speed, 0);
        chk("mid_rst_valid", speed_valid, 0);
        reset = 1'b0;
        n_e = 0;
        last_e = 0;
        prev_e = 0;
        tick(40);
        chk("mid_rst_nvalid", n_valid - v0, 0);
        measure("post_rst", model_speed(cyc), 0);

        p = $urandom_range(300, 1500);
        steady("post_rst_ride", p, 0);
        tick(TMO - 100 - (cyc - last_e - PLAT));
        for (int k = 0; k < 20 && !stable(cyc); k++) tick(1);
        measure("slow", model_speed(cyc), 0);
        tick(TMO + 100 - (cyc - last_e - PLAT));
        measure("timeout", model_speed(cyc), 0);
        chk("final_pulses", n_pulse, exp_pulses);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/speed_meter.md
# speed_meter

Measures wheel-revolution period from the raw reed/hall sensor and converts it to road speed for the bike-computer datapath. Sits upstream of the display/control stage. It answers that stage's `speed_start` pulse with a `speed` word and a one-cycle `speed_valid`. It also emits a per-revolution pulse for the distance counter. Arithmetic is a shared-nothing sequential divider, one quotient bit per cycle.

## Interface
- `SPEED_WIDTH`, 12: output speed width, integer km/h.
- `CLK_HZ`, 1_000_000: clock frequency.
- `CIRC_MM`, 2133: wheel circumference in mm.
- `PERIOD_WIDTH`, 24: period counter and divider width; also the divider cycle count.
- `DEB_CYCLES`, 16: debounce stability window in cycles.
- `TIMEOUT_CYCLES`, 3_000_000: period at or above which speed reports 0.
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high; `clock` domain.
- `wheel`  in  1  raw sensor, asynchronous, active-high.
- `speed_start`  in  1  one-cycle measurement request.
- `speed`  out  SPEED_WIDTH  last computed speed, km/h.
- `speed_valid`  out  1  one-cycle pulse; `speed` updated this cycle.
- `busy`  out  1  measurement in progress.
- `wheel_pulse`  out  1  one-cycle pulse per debounced rising edge.

## Operation
- **Constant:** K = CIRC_MM·CLK_HZ·36/10000, truncated; 7_678_800 at defaults. It must fit in PERIOD_WIDTH; elaboration error otherwise.
- **Input path:**
  - 2-flop synchroniser, then debounce.
  - Debounced level changes only after the synchronised input holds the new value for DEB_CYCLES consecutive cycles.
  - `wheel_pulse` fires on each debounced 0→1 transition.
- **Period counter `cnt`:**
  - Set to 1 on `wheel_pulse`, otherwise increments.
  - Saturates at TIMEOUT_CYCLES.
  - On `wheel_pulse`, `last_period` <= `cnt`. Pulses P cycles apart give `last_period` = P.
  - `seen2` sets after the second `wheel_pulse` since reset.
- **FSM states:** IDLE, LOAD, DIV, DONE.
  - IDLE: on `speed_start`, go to LOAD. Snapshot `d` = max(`last_period`, `cnt`), so speed decays while slowing. Snapshot `zero` = !`seen2` || `d` >= TIMEOUT_CYCLES.
  - LOAD: initialise divider with dividend K and divisor `d`; go to DIV.
  - DIV: PERIOD_WIDTH restoring-division iterations, one per cycle; then go to DONE.
  - DONE: write `speed`, pulse `speed_valid`, return to IDLE.
- **Result selection, in DONE:**
  - If `zero`: `speed` = 0, and the quotient is discarded.
  - Else if quotient > 2^SPEED_WIDTH−1: `speed` = all ones (saturate).
  - Else: `speed` = quotient.
- `speed` holds its value between updates.
- `busy` = state != IDLE.

## Timing
- **Reset values:** `speed` 0, `speed_valid` 0, `busy` 0, `wheel_pulse` 0. FSM in IDLE, `cnt` 0, `last_period` 0, `seen2` 0, debounced level 0.
- **Latency:** `speed_start` sampled in cycle N gives `speed_valid` in cycle N+PERIOD_WIDTH+2 (N+26 at defaults). Latency is fixed, including the zero and saturate cases.
- **`busy`:** high from N+1 through the `speed_valid` cycle inclusive.
- **`speed_start` while busy:** ignored, not queued.
- **Sensor to pulse:** a clean rising edge on `wheel` produces `wheel_pulse` 2+DEB_CYCLES cycles later, ±1.
- **Simultaneous events:** `wheel_pulse` and `speed_start` in the same cycle: the snapshot uses the pre-update `cnt`/`last_period`.
- **Reset mid-operation:** reset during LOAD/DIV/DONE aborts the measurement; no `speed_valid` is issued.
- **Sensor glitches:** a glitch shorter than DEB_CYCLES produces no pulse.

## Structure
- Shared package `bike_pkg`:
  - SPEED_WIDTH, CLK_HZ, CIRC_MM.
  - Derived K as a localparam function.
  - FSM state typedef.
- Sub-module `seq_divider`:
  - Parameter WIDTH.
  - Ports: `load`, `dividend`, `divisor`, `quotient`, `done`.
  - Restoring algorithm, WIDTH cycles.
  - Reusable by the average-speed block.
- Debounce logic stays inline.

## Test plan
- **Startup:** after reset, `speed_start` with no wheel edges → `speed_valid` 26 cycles later with `speed` = 0.
- **Steady 27 km/h:** clean wheel edges every 276_480 cycles; after the third edge, `speed_start` → `speed` = 27 (K/276_480 = 27.77). `wheel_pulse` fires once per edge.
- **Steady 76 km/h:** edges every 100_000 cycles → 76. Then stop the edges; `speed_start` issued 200_000 cycles after the last edge → 38. A `speed_start` after 3_000_000 idle cycles → 0.
- **Saturation:** edges every 1_000 cycles → 7678 exceeds 4095, so `speed` = 4095.
- **Glitch rejection and collisions:**
  - 10-cycle `wheel` pulses produce no `wheel_pulse` and leave the period unchanged.
  - `speed_start` re-asserted while `busy` produces exactly one `speed_valid`.
  - `speed_start` coincident with `wheel_pulse` uses the old period.
- **Reset mid-division:** reset 10 cycles after `speed_start` → no `speed_valid`, `speed` = 0, `busy` = 0 the next cycle. A subsequent `speed_start` operates normally.
